// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the core's memory stage and the data-memory
// responder.
//   req_valid    core -> mem  request present
//   req_ready    mem  -> core responder can accept a request this cycle
//   req_write    core -> mem  1 = store, 0 = load
//   req_addr     core -> mem  byte address
//   req_wdata    core -> mem  store data (byte/half taken from the low bits)
//   req_size     core -> mem  00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned core -> mem  loads only: 1 = zero-extend, 0 = sign-extend
//   rsp_valid    mem  -> core one-cycle response strobe
//   rsp_rdata    mem  -> core extended load result; 0 for stores and errors
//   rsp_error    mem  -> core error flag, meaningful only with rsp_valid
// Modports: master = core side, slave = responder side.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the core's data-memory loads and stores. Owns a
// word-wide on-chip RAM, accepts one request at a time, performs sub-word
// stores as read-modify-write and returns sign/zero-extended load data with a
// one-cycle response strobe. Misaligned, out-of-range and illegal-size
// accesses are answered with rsp_error and never touch the RAM.
//
// Latency from the acceptance edge: error 1, word store 1, sub-word store 2,
// load 2.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   bus        dmem_responder_if.slave request/response bundle
//   cnt_loads  successful load count   (only with DMEM_RSP_PERF_COUNTERS_EN)
//   cnt_stores successful store count  (only with DMEM_RSP_PERF_COUNTERS_EN)
//   cnt_errors error response count    (only with DMEM_RSP_PERF_COUNTERS_EN)
//
// Optional feature macro: DMEM_RSP_PERF_COUNTERS_EN adds three wrapping
// 32-bit response counters, cleared by reset.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
   parameter int          DEPTH_WORDS = 16384,
   parameter int          AW          = 14
) (
   input  logic            clock,
   input  logic            reset,
   dmem_responder_if.slave bus
`ifdef DMEM_RSP_PERF_COUNTERS_EN
   ,
   output logic [31:0]     cnt_loads,
   output logic [31:0]     cnt_stores,
   output logic [31:0]     cnt_errors
`endif
);

   if (AW != $clog2(DEPTH_WORDS)) begin : g_aw_check
      $error("dmem_responder: AW must equal clog2(DEPTH_WORDS)");
   end

   typedef enum logic [2:0] {
      IDLE,
      LD_RD,
      LD_FMT,
      ST_WR,
      RMW_RD,
      RMW_WR
   } state_t;

   // 33-bit bounds so that a window ending at 2^32 cannot wrap.
   localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'(DEPTH_WORDS) << 2);

   state_t        state;
   state_t        state_next;

   logic          accept;
   logic          in_range;
   logic          req_err;
   logic [AW-1:0] idx_in;

   // Request fields captured at acceptance.
   logic [AW-1:0] idx_q;
   logic [1:0]    lane_q;
   logic [1:0]    size_q;
   logic          zero_ext_q;
   logic [31:0]   wdata_q;

   logic          err_pending;
   logic [31:0]   rd_word;
   logic [31:0]   ram [DEPTH_WORDS];

   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   merged;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_result;
   logic          fire_load;
   logic          fire_store;
   logic          fire_error;

   // ---------------------------------------------------------------- decode
   assign bus.req_ready = (state == IDLE);
   assign accept        = bus.req_valid && bus.req_ready;

   assign in_range = ({1'b0, bus.req_addr} >= BASE_EXT) &&
                     ({1'b0, bus.req_addr} <  LIMIT_EXT);
   assign idx_in   = AW'((bus.req_addr - BASE_ADDR) >> 2);
   assign req_err  = !in_range ||
                     (bus.req_size == 2'b11) ||
                     (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

   // --------------------------------------------------------- state register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // ------------------------------------------------------------- next state
   always_comb begin
      // NOTE: default assignment first so no path leaves state_next unassigned
      // (an unassigned path would infer a latch).
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept && !req_err) begin
               if (!bus.req_write)             state_next = LD_RD;
               else if (bus.req_size == 2'b10) state_next = ST_WR;
               else                            state_next = RMW_RD;
            end
         end
         LD_RD:   state_next = LD_FMT;
         LD_FMT:  state_next = IDLE;
         ST_WR:   state_next = IDLE;
         RMW_RD:  state_next = RMW_WR;
         RMW_WR:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      case (lane_q)
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

      case (size_q)
         2'b00:   load_result = zero_ext_q ? {24'h0, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_result = zero_ext_q ? {16'h0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
         default: load_result = rd_word;
      endcase

      // Only the addressed lanes of the word read in RMW_RD are replaced.
      merged = rd_word;
      if (size_q == 2'b00) begin
         case (lane_q)
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (lane_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0]  = wdata_q[15:0];
      end

      mem_we     = (state == ST_WR) || (state == RMW_WR);
      mem_wdata  = (state == RMW_WR) ? merged : wdata_q;
      fire_load  = (state == LD_FMT);
      fire_store = mem_we;
      fire_error = err_pending;
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clock) begin
      if (accept) begin
         idx_q      <= idx_in;
         lane_q     <= bus.req_addr[1:0];
         size_q     <= bus.req_size;
         zero_ext_q <= bus.req_unsigned;
         wdata_q    <= bus.req_wdata;
      end
   end

   // An error stays in IDLE, so its response is carried by a one-cycle flag;
   // a new request may be accepted while that flag is draining.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_pending   <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_error <= 1'b0;
      end else begin
         err_pending   <= accept && req_err;
         bus.rsp_valid <= fire_load || fire_store || fire_error;
         bus.rsp_error <= fire_error;
         bus.rsp_rdata <= fire_load ? load_result : '0;
      end
   end

   // NOTE: the RAM is deliberately left out of reset; only the write enable is
   // gated, so a store due on a reset edge leaves the contents unchanged.
   always_ff @(posedge clock) begin
      if (!reset && mem_we) ram[idx_q] <= mem_wdata;
      if (state == LD_RD || state == RMW_RD) rd_word <= ram[idx_q];
   end

`ifdef DMEM_RSP_PERF_COUNTERS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_loads  <= '0;
         cnt_stores <= '0;
         cnt_errors <= '0;
      end else begin
         if (fire_load)  cnt_loads  <= cnt_loads  + 32'd1;
         if (fire_store) cnt_stores <= cnt_stores + 32'd1;
         if (fire_error) cnt_errors <= cnt_errors + 32'd1;
      end
   end
`endif

endmodule
